// File: rtl/ser_pkg.sv
// ============================================================================
// Module   : ser_pkg
// Purpose  : Shared types, default constants and helpers for bit_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam int   C_DEF_WIDTH    = 8;
  localparam logic C_DEF_IDLE_BIT = 1'b0;

  // Bit count index width; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Purpose  : Valid/ready parallel-to-serial converter, one bit per clock,
//            back-to-back words with no gap. Define SER_LSB_FIRST_EN for
//            LSB-first shifting (default MSB-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = C_DEF_WIDTH,
  parameter logic IDLE_BIT = C_DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int               CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  ser_state_t       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [WIDTH-1:0] r_shreg, w_shreg_nx;
  logic             r_sout, w_sout_nx;
  logic             r_sout_valid, w_sout_valid_nx;
  logic             r_last, w_last_nx;
  logic             w_ready;
  logic             w_accept;

  // Ready while idle or while the final bit of the current word is on sout.
  assign w_ready   = rst & ((r_state == ST_IDLE) | (r_cnt == c_last_cnt));
  assign w_accept  = in_valid & w_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_shreg_nx      = r_shreg;
    w_sout_nx       = r_sout;
    w_sout_valid_nx = r_sout_valid;
    w_last_nx       = r_last;

    if (w_accept) begin
`ifdef SER_LSB_FIRST_EN
      w_sout_nx  = in_data[0];
      w_shreg_nx = in_data >> 1;
`else
      w_sout_nx  = in_data[WIDTH-1];
      w_shreg_nx = in_data << 1;
`endif
      w_sout_valid_nx = 1'b1;
      w_last_nx       = 1'b0;
      w_cnt_nx        = '0;
      w_state_nx      = ST_SHIFT;
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt != c_last_cnt) begin
`ifdef SER_LSB_FIRST_EN
        w_sout_nx  = r_shreg[0];
        w_shreg_nx = r_shreg >> 1;
`else
        w_sout_nx  = r_shreg[WIDTH-1];
        w_shreg_nx = r_shreg << 1;
`endif
        w_sout_valid_nx = 1'b1;
        w_cnt_nx        = w_cnt_inc;
        w_last_nx       = (w_cnt_inc == c_last_cnt);
      end else begin
        w_sout_nx       = IDLE_BIT;
        w_sout_valid_nx = 1'b0;
        w_last_nx       = 1'b0;
        w_state_nx      = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_sout       <= IDLE_BIT;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_shreg      <= w_shreg_nx;
      r_sout       <= w_sout_nx;
      r_sout_valid <= w_sout_valid_nx;
      r_last       <= w_last_nx;
    end
  end

  assign in_ready   = w_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign last_bit   = r_last;
  assign busy       = (r_state == ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Directed self-checking bench for bit_serializer (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             last_bit;
  logic             busy;

  int total;
  int bad;

  bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .last_bit  (last_bit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit i of the serial stream for a given word (i=0 is the first bit out).
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef SER_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) tick();
    total++; if (sout !== IDLE_BIT) begin bad++; $display("FAIL reset_sout got=%b exp=%b", sout, IDLE_BIT); end
    total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL reset_sout_valid got=%b exp=0", sout_valid); end
    total++; if (last_bit !== 1'b0) begin bad++; $display("FAIL reset_last_bit got=%b exp=0", last_bit); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] w;
    w = 8'hB0;
    in_data = w; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < WIDTH; i++) begin
      total++;
      if (sout !== exp_bit(w, i) || sout_valid !== 1'b1 || last_bit !== (i == WIDTH-1) || busy !== 1'b1) begin
        bad++;
        $display("FAIL single_bit%0d got sout=%b v=%b last=%b busy=%b exp sout=%b v=1 last=%b busy=1",
                 i, sout, sout_valid, last_bit, busy, exp_bit(w, i), (i == WIDTH-1));
      end
      tick();
    end
    total++;
    if (sout !== IDLE_BIT || sout_valid !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0) begin
      bad++;
      $display("FAIL single_after got sout=%b v=%b busy=%b last=%b exp sout=%b v=0 busy=0 last=0",
               sout, sout_valid, busy, last_bit, IDLE_BIT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2*WIDTH-1:0] stream;
    logic [WIDTH-1:0]   a, b;
    a = 8'h5A; b = 8'hC3;
    in_data = a; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
    tick();
    in_data = b;
    for (int i = 0; i < 2*WIDTH; i++) begin
      logic eb;
      eb = (i < WIDTH) ? exp_bit(a, i) : exp_bit(b, i - WIDTH);
      stream[2*WIDTH-1-i] = sout;
      total++;
      if (sout !== eb || sout_valid !== 1'b1 || last_bit !== (i == WIDTH-1 || i == 2*WIDTH-1)
          || in_ready !== (i == WIDTH-1 || i == 2*WIDTH-1)) begin
        bad++;
        $display("FAIL b2b_bit%0d got sout=%b v=%b last=%b rdy=%b exp sout=%b v=1 last=%b rdy=%b",
                 i, sout, sout_valid, last_bit, in_ready, eb,
                 (i == WIDTH-1 || i == 2*WIDTH-1), (i == WIDTH-1 || i == 2*WIDTH-1));
      end
      tick();
      if (i == WIDTH-1) in_valid = 1'b0;
    end
`ifndef SER_LSB_FIRST_EN
    total++;
    if (stream !== 16'b01011010_11000011) begin
      bad++; $display("FAIL b2b_stream got=%b exp=0101101011000011", stream);
    end
`endif
    total++; if (sout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_after got v=%b busy=%b exp 0 0", sout_valid, busy); end
    tick();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] a, b;
    a = 8'h81; b = 8'hE7;
    in_data = a; in_valid = 1'b1;
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      in_data = (i == WIDTH-1) ? b : (8'h3C + 8'(i));
      #1;
      total++;
      if (sout !== exp_bit(a, i) || in_ready !== (i == WIDTH-1) || sout_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_bit%0d got sout=%b rdy=%b v=%b exp sout=%b rdy=%b v=1",
                 i, sout, in_ready, sout_valid, exp_bit(a, i), (i == WIDTH-1));
      end
      tick();
    end
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < WIDTH; i++) begin
      total++;
      if (sout !== exp_bit(b, i) || sout_valid !== 1'b1 || last_bit !== (i == WIDTH-1)) begin
        bad++;
        $display("FAIL stall_load_bit%0d got sout=%b v=%b last=%b exp sout=%b v=1 last=%b",
                 i, sout, sout_valid, last_bit, exp_bit(b, i), (i == WIDTH-1));
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [WIDTH-1:0] w;
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (sout !== 1'b1 || sout_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got sout=%b v=%b exp 1 1", sout, sout_valid); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    tick();
    total++;
    if (sout !== IDLE_BIT || sout_valid !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flush got sout=%b v=%b busy=%b last=%b exp sout=%b v=0 busy=0 last=0",
               sout, sout_valid, busy, last_bit, IDLE_BIT);
    end
    rst = 1'b1;
    w = 8'h96;
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      total++;
      if (sout !== exp_bit(w, i) || sout_valid !== 1'b1 || last_bit !== (i == WIDTH-1)) begin
        bad++;
        $display("FAIL midrst_new_bit%0d got sout=%b v=%b last=%b exp sout=%b v=1 last=%b",
                 i, sout, sout_valid, last_bit, exp_bit(w, i), (i == WIDTH-1));
      end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_end_busy got=%b exp=0", busy); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
